// File: rtl/pm_seq.sv
// pm_seq: WIDTH x WIDTH radix-2 sequential multiplier, signed/unsigned per op,
// valid/ready on both sides. One step per cycle, WIDTH cycles per product.
module pm_seq #(
    parameter  int WIDTH = 32,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               op,
    input  logic [WIDTH-1:0]   mc,
    input  logic [WIDTH-1:0]   mp,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, mplr, mcand;
    logic             sgn;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   ext_acc, ext_mc, sum;
    logic             last, accept;

    assign in_ready = (state == IDLE) | ((state == HOLD) & out_ready);
    assign busy     = (state == RUN);
    assign accept   = in_valid & in_ready;
    assign last     = (cnt == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last) state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = in_valid ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One step: WIDTH+1 bit partial sum keeps the carry (unsigned) or sign (signed);
    // the last signed step subtracts since the multiplier MSB weighs -2^(WIDTH-1).
    always_comb begin
        ext_acc = {sgn & acc[WIDTH-1], acc};
        ext_mc  = {sgn & mcand[WIDTH-1], mcand};
        sum     = ext_acc;
        if (mplr[0]) sum = (last & sgn) ? (ext_acc - ext_mc) : (ext_acc + ext_mc);
    end

    // Operand latch and shift-add datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            mplr  <= '0;
            mcand <= '0;
            sgn   <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            acc   <= '0;
            mplr  <= mp;
            mcand <= mc;
            sgn   <= op;
            cnt   <= '0;
        end else if (state == RUN) begin
            acc  <= sum[WIDTH:1];
            mplr <= {sum[0], mplr[WIDTH-1:1]};
            if (!last) cnt <= cnt + CW'(1);
        end
    end

    // Result register: loaded on the final step, held until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p         <= '0;
            out_valid <= 1'b0;
        end else if ((state == RUN) && last) begin
            p         <= {sum[WIDTH:1], sum[0], mplr[WIDTH-1:1]};
            out_valid <= 1'b1;
        end else if ((state == HOLD) && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/pm_seq.md
Name: pm_seq

Overview:
Parametrised sequential multiplier, the next generation of the team's 32x32 serial multiplier.
- Generalised to WIDTH bits, with a per-operation signed/unsigned mode (the `op` port now takes effect).
- Uses valid/ready handshakes on input and output instead of start/done. The result is held under backpressure, and a new operand pair can be accepted on the same cycle the previous result is taken.
- Sits between an operand-issue unit and a result consumer in the datapath; one multiply takes WIDTH cycles.

Parameters:
- WIDTH, 32, operand width in bits; legal range 2..64; product is 2*WIDTH bits.
- CW, $clog2(WIDTH), step-counter width (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair and op are valid.
- in_ready  out  1  block can accept operands this cycle.
- op  in  1  0 = unsigned multiply, 1 = signed (two's complement); sampled with operands.
- mc  in  WIDTH  multiplicand.
- mp  in  WIDTH  multiplier.
- out_valid  out  1  p holds a completed product.
- out_ready  in  1  consumer takes p this cycle.
- p  out  2*WIDTH  product register.
- busy  out  1  high while a multiply is in progress (state RUN).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, step counter=0, internal accumulator/multiplier registers=0.
  - out_valid=0, p=0, busy=0.
  - A reset asserted mid-RUN or in HOLD aborts the operation; no result is produced.
- States: IDLE, RUN, HOLD.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). It is purely combinational, with no dependency on in_valid.
- Accept: on a rising edge with in_valid & in_ready.
  - mc, mp and op are latched; later changes to these inputs are ignored until the next accept.
  - Counter is cleared; state goes to RUN.
- RUN: one radix-2 step per cycle, WIDTH steps, counter 0..WIDTH-1.
  - Step i: if multiplier bit i = 1, add the (WIDTH+1)-bit extended multiplicand to the upper accumulator. Extension is sign-extension when op=1, zero-extension when op=0.
  - Then shift the {acc, multiplier} register right by 1. The shift is arithmetic when op=1; when op=0 the adder carry is shifted in.
  - Step WIDTH-1 with op=1 subtracts instead of adds, because the MSB has negative weight.
  - Any equivalent implementation is acceptable provided p is bit-exact.
- Completion: on the edge ending step WIDTH-1:
  - p <= exact 2*WIDTH-bit product; out_valid <= 1; state -> HOLD.
  - Latency is exactly WIDTH clock edges from the accept edge to out_valid high.
- HOLD: p and out_valid remain stable while out_ready=0 (indefinite backpressure).
  - out_ready=1 & in_valid=1: result taken and new operands accepted on the same edge. out_valid <= 0, state -> RUN.
  - out_ready=1 & in_valid=0: out_valid <= 0, state -> IDLE.
- p keeps its last value after handoff, until the next completion overwrites it. p is only meaningful while out_valid=1.
- busy = (state==RUN). in_ready=0 throughout RUN, and in_valid is ignored in RUN.
- Sustained throughput with in_valid=out_ready=1: one product every WIDTH+1 cycles.
- Boundary values:
  - Signed: most-negative x most-negative = +2^(2*WIDTH-2). No overflow is possible; the full product always fits.
  - Either operand 0 gives p=0 in both modes.
- Counter terminal value is WIDTH-1. No wrap or extra cycle in RUN.

Test Plan:
- WIDTH=32, op=0, mc=mp=0xFFFFFFFF:
  - p=0xFFFFFFFE00000001.
  - out_valid rises exactly 32 edges after the accept edge.
  - busy high for exactly 32 cycles.
- WIDTH=32, op=1, each case -> p:
  - mc=-3 (0xFFFFFFFD), mp=5 -> 0xFFFFFFFFFFFFFFF1.
  - mc=mp=0x80000000 -> 0x4000000000000000.
  - mc=mp=0xFFFFFFFF -> 0x0000000000000001.
- Backpressure: complete 0x80000000 x 2 with op=0 (p=0x0000000100000000) and hold out_ready=0 for 10 cycles.
  - p and out_valid remain stable; in_ready=0; a pending in_valid is not accepted.
  - Then pulse out_ready -> state IDLE, out_valid=0.
- Back-to-back: in_valid and out_ready held 1, four random operand pairs with mixed op.
  - Every product matches the reference model.
  - Results spaced exactly 33 cycles apart.
  - The next pair is accepted on the same edge each result is taken.
- Reset mid-operation: drop rst_n at step 10 of a RUN.
  - Immediately: out_valid=0, p=0, busy=0, state IDLE.
  - After release, a fresh multiply 7 x 6 (op=0) gives p=42.
- WIDTH=8 instance:
  - op=1, mc=mp=0x80 -> p=0x4000.
  - op=0, mc=mp=0xFF -> p=0xFE01.
  - Latency is 8 cycles.
